// File: rtl/regfile_sb.sv
// Pipeline register file: two combinational read ports, one byte-enabled writeback port,
// and a per-register in-flight-writer counter for RAW busy flags. Optional macro: REGFILE_BYPASS_EN.
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PEND_W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   rs_addr,
  input  logic [ADDR_W-1:0]   rt_addr,
  output logic [DATA_W-1:0]   rs_data,
  output logic [DATA_W-1:0]   rt_data,
  output logic                rs_busy,
  output logic                rt_busy,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                iss_en,
  input  logic [ADDR_W-1:0]   iss_addr,
  output logic                iss_ready,
  output logic                err_uflow
);

  localparam int NREG  = 1 << ADDR_W;
  localparam int NBYTE = DATA_W / 8;
  localparam logic [PEND_W-1:0] PMAX = '1;

  logic [DATA_W-1:0] reg_q [NREG];
  logic [DATA_W-1:0] reg_d [NREG];
  logic [PEND_W-1:0] cnt_q [NREG];
  logic [PEND_W-1:0] cnt_d [NREG];
  logic              err_uflow_q, err_uflow_d;
  logic [DATA_W-1:0] wr_mask;
  logic              iss_acc;
  logic              retire;
  logic              same_addr;

  always_comb begin
    wr_mask = '0;
    for (int b = 0; b < NBYTE; b++) begin
      wr_mask[b*8 +: 8] = {8{wr_be[b]}};
    end
  end

  // Issue handshake: an issue transfers on a rising edge when iss_en && iss_ready.
  // iss_ready depends only on registered counters and iss_addr, never on iss_en or
  // on a writeback in the same cycle; upstream holds iss_en/iss_addr while stalled.
  assign iss_ready = (iss_addr == '0) || (cnt_q[iss_addr] != PMAX);
  assign iss_acc   = iss_en && iss_ready && (iss_addr != '0);
  assign retire    = wr_en && (wr_addr != '0);
  assign same_addr = iss_acc && retire && (iss_addr == wr_addr);

  always_comb begin
    reg_d       = reg_q;
    cnt_d       = cnt_q;
    err_uflow_d = err_uflow_q;
    if (retire) begin
      reg_d[wr_addr] = (reg_q[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
    end
    // A same-register issue and retire net to zero, so no underflow can occur there.
    if (iss_acc && !same_addr) begin
      cnt_d[iss_addr] = cnt_q[iss_addr] + PEND_W'(1);
    end
    if (retire && !same_addr) begin
      if (cnt_q[wr_addr] == '0) begin
        err_uflow_d = 1'b1;
      end else begin
        cnt_d[wr_addr] = cnt_q[wr_addr] - PEND_W'(1);
      end
    end
    reg_d[0] = '0;
    cnt_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        reg_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      err_uflow_q <= 1'b0;
    end else begin
      reg_q       <= reg_d;
      cnt_q       <= cnt_d;
      err_uflow_q <= err_uflow_d;
    end
  end

  always_comb begin
    rs_data = (rs_addr == '0) ? '0 : reg_q[rs_addr];
    rt_data = (rt_addr == '0) ? '0 : reg_q[rt_addr];
    rs_busy = (cnt_q[rs_addr] != '0);
    rt_busy = (cnt_q[rt_addr] != '0);
`ifdef REGFILE_BYPASS_EN
    // Write-through: a port reading the register being retired sees the post-edge view.
    if (rst_n && retire && (wr_addr == rs_addr)) begin
      rs_data = reg_d[rs_addr];
      rs_busy = (cnt_d[rs_addr] != '0);
    end
    if (rst_n && retire && (wr_addr == rt_addr)) begin
      rt_data = reg_d[rt_addr];
      rt_busy = (cnt_d[rt_addr] != '0);
    end
`else
    // Registered-only view: a write becomes visible the cycle after its edge.
`endif
  end

  assign err_uflow = err_uflow_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus random traffic,
// compared each cycle against an array/counter reference model.
module tb_regfile_sb;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NR   = 32;
  localparam int PMAX = 3;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] rs_addr, rt_addr, wr_addr, iss_addr;
  logic [DW-1:0] rs_data, rt_data, wr_data;
  logic          rs_busy, rt_busy, wr_en, iss_en, iss_ready, err_uflow;
  logic [3:0]    wr_be;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .PEND_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data),
    .rs_busy(rs_busy), .rt_busy(rt_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_ready(iss_ready),
    .err_uflow(err_uflow)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0] m_reg [NR];
  int            m_cnt [NR];
  bit            m_err;
  logic [DW-1:0] n_reg [NR];
  int            n_cnt [NR];
  bit            n_err;

  // Scoreboard
  logic [DW-1:0] exp_q [$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NR; i++) begin
      m_reg[i] = '0;
      m_cnt[i] = 0;
    end
    m_err = 1'b0;
  endtask

  // Next state from the rules: accepted issue counts first, then the retire is
  // checked against the incremented count.
  task automatic model_next();
    int ia, wa;
    ia = int'(iss_addr);
    wa = int'(wr_addr);
    n_reg = m_reg;
    n_cnt = m_cnt;
    n_err = m_err;
    if (iss_en && ia != 0 && m_cnt[ia] < PMAX) n_cnt[ia] = n_cnt[ia] + 1;
    if (wr_en && wa != 0) begin
      for (int b = 0; b < 4; b++)
        if (wr_be[b]) n_reg[wa][8*b +: 8] = wr_data[8*b +: 8];
      if (n_cnt[wa] == 0) n_err = 1'b1;
      else n_cnt[wa] = n_cnt[wa] - 1;
    end
  endtask

  // Driver tasks
  task automatic set_in(input logic we, input int wa, input logic [DW-1:0] wd,
                        input logic [3:0] be, input logic ie, input int ia,
                        input int ra, input int rb);
    wr_en = we;  wr_addr = AW'(wa); wr_data = wd; wr_be = be;
    iss_en = ie; iss_addr = AW'(ia);
    rs_addr = AW'(ra); rt_addr = AW'(rb);
  endtask

  task automatic idle(input int ra, input int rb);
    set_in(1'b0, 0, '0, 4'h0, 1'b0, 0, ra, rb);
  endtask

  // Called just after a negedge with inputs set: check outputs, then clock the model.
  task automatic cycle();
    logic [DW-1:0] e_rs, e_rt;
    logic          e_rsb, e_rtb, e_rdy;
    int            ra, rb;
    #1;
    ra = int'(rs_addr);
    rb = int'(rt_addr);
    model_next();
    e_rs  = (ra == 0) ? '0 : m_reg[ra];
    e_rt  = (rb == 0) ? '0 : m_reg[rb];
    e_rsb = (m_cnt[ra] != 0);
    e_rtb = (m_cnt[rb] != 0);
`ifdef REGFILE_BYPASS_EN
    if (rst_n && wr_en && wr_addr != '0 && wr_addr == rs_addr) begin
      e_rs = n_reg[ra]; e_rsb = (n_cnt[ra] != 0);
    end
    if (rst_n && wr_en && wr_addr != '0 && wr_addr == rt_addr) begin
      e_rt = n_reg[rb]; e_rtb = (n_cnt[rb] != 0);
    end
`endif
    e_rdy = (iss_addr == '0) || (m_cnt[int'(iss_addr)] != PMAX);
    exp_q.push_back(e_rs);
    exp_q.push_back(e_rt);
    check("rs_data", rs_data, exp_q.pop_front());
    check("rt_data", rt_data, exp_q.pop_front());
    check("rs_busy", 32'(rs_busy), 32'(e_rsb));
    check("rt_busy", 32'(rt_busy), 32'(e_rtb));
    check("iss_ready", 32'(iss_ready), 32'(e_rdy));
    check("err_uflow", 32'(err_uflow), 32'(m_err));
    @(posedge clk);
    if (rst_n) begin
      m_reg = n_reg;
      m_cnt = n_cnt;
      m_err = n_err;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle(0, 0);
    model_clear();
    @(negedge clk);
    do_reset();

    // Fresh state on every address
    for (int i = 0; i < NR; i++) begin
      idle(i, NR - 1 - i);
      cycle();
    end

    // Byte-enable merge on r5 (issue alongside each writeback so no underflow)
    set_in(1'b1, 5, 32'hDEADBEEF, 4'hF, 1'b1, 5, 5, 0); cycle();
    set_in(1'b1, 5, 32'h0000AA00, 4'b0010, 1'b1, 5, 5, 0); cycle();
    idle(5, 0); #1;
    check("r5_merge", rs_data, 32'hDEADAAEF);
    check("r5_no_err", 32'(err_uflow), 32'h0);
    cycle();

    // Register 0 ignores writes and issues
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, 0, 32'hFFFFFFFF, 4'hF, 1'b1, 0, 0, 0); #1;
      check("r0_ready", 32'(iss_ready), 32'h1);
      cycle();
    end
    idle(0, 0); #1;
    check("r0_zero", rs_data, 32'h0);
    check("r0_busy", 32'(rs_busy), 32'h0);
    cycle();

    // Saturate r7's counter, then drain it
    for (int k = 0; k < 3; k++) begin
      set_in(1'b0, 0, '0, 4'h0, 1'b1, 7, 0, 7); cycle();
    end
    set_in(1'b0, 0, '0, 4'h0, 1'b1, 7, 0, 7); #1;
    check("r7_full_ready", 32'(iss_ready), 32'h0);
    check("r7_full_busy", 32'(rt_busy), 32'h1);
    cycle();
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, 7, 32'h7777_0000 + 32'(k), 4'hF, 1'b0, 0, 0, 7); cycle();
    end
    idle(0, 7); #1;
    check("r7_drained_busy", 32'(rt_busy), 32'h0);
    check("r7_no_err", 32'(err_uflow), 32'h0);
    cycle();

    // Read-during-writeback on r3
    set_in(1'b0, 0, '0, 4'h0, 1'b1, 3, 3, 0); cycle();
    set_in(1'b1, 3, 32'h12345678, 4'hF, 1'b0, 0, 3, 0); #1;
`ifdef REGFILE_BYPASS_EN
    check("r3_same_data", rs_data, 32'h12345678);
    check("r3_same_busy", 32'(rs_busy), 32'h0);
`else
    check("r3_same_data", rs_data, 32'h0);
    check("r3_same_busy", 32'(rs_busy), 32'h1);
`endif
    cycle();
    idle(3, 0); #1;
    check("r3_next_data", rs_data, 32'h12345678);
    check("r3_next_busy", 32'(rs_busy), 32'h0);
    cycle();

    // Underflow is sticky until reset
    set_in(1'b1, 9, 32'h99, 4'hF, 1'b0, 0, 0, 0); cycle();
    idle(0, 0); #1;
    check("uflow_set", 32'(err_uflow), 32'h1);
    repeat (3) cycle();
    check("uflow_held", 32'(err_uflow), 32'h1);
    do_reset();
    idle(0, 0); #1;
    check("uflow_cleared", 32'(err_uflow), 32'h0);
    cycle();

    // Asynchronous reset between edges with cnt[r4]=2
    repeat (2) begin
      set_in(1'b0, 0, '0, 4'h0, 1'b1, 4, 4, 0); cycle();
    end
    idle(4, 0); #2;
    check("r4_busy_pre", 32'(rs_busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("r4_busy_async", 32'(rs_busy), 32'h0);
    model_clear();
    @(negedge clk);
    cycle();
    rst_n = 1'b1;
    idle(4, 0);
    cycle();

    // Random traffic concentrated on a few registers to create hazards
    for (int k = 0; k < 600; k++) begin
      set_in($urandom_range(0, 2) == 0, int'($urandom_range(0, 7)), $urandom,
             4'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
             int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 7)));
      cycle();
      if (k == 300) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
